// File: rtl/pal_sync_sep.sv
// Composite PAL sync separator: recovers filtered sync, line/field strobes,
// field parity, a line count and a lock indication from 8-bit ADC samples.
module pal_sync_sep #(
    parameter logic [7:0] SYNC_LEVEL = 8'd40,
    parameter int         GLITCH     = 3,
    parameter int         HS_MIN     = 50,
    parameter int         HS_MAX     = 85,
    parameter int         EQ_MIN     = 20,
    parameter int         EQ_MAX     = 49,
    parameter int         BROAD_MIN  = 300,
    parameter int         LINE_MIN   = 880,
    parameter int         LINE_MAX   = 950,
    parameter int         HALF_MIN   = 430,
    parameter int         HALF_MAX   = 485
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    output logic       sync_n,
    output logic       hsync,
    output logic       vsync,
    output logic       field,
    output logic [9:0] line,
    output logic       locked,
    output logic       pulse_err
);

    typedef enum logic [2:0] {
        S_SEARCH,
        S_LINES,
        S_PRE_EQ,
        S_BROAD,
        S_POST_EQ
    } vstate_t;

    typedef enum logic [1:0] {
        P_NORMAL,
        P_EQ,
        P_BROAD,
        P_ERR
    } pclass_t;

    logic [7:0]  sample_q;
    logic        below;
    logic [2:0]  run_cnt;
    logic        toggle;
    logic        fall;
    logic        rise;
    logic        rise_q;
    logic [9:0]  wcnt;
    logic [10:0] pcnt;
    logic [10:0] period;
    logic [2:0]  lock_cnt;
    logic        parity_q;
    logic        period_line;
    logic        period_half;
    logic        pcnt_over;
    pclass_t     cls;
    vstate_t     state_q;
    vstate_t     state_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        perr_next;
    logic        parity_next;

    assign below  = (sample_q < SYNC_LEVEL);
    // The filter flips once GLITCH consecutive samples disagree with sync_n.
    assign toggle = (below == sync_n) && (run_cnt == 3'(GLITCH - 1));
    assign fall   = toggle && sync_n;
    assign rise   = toggle && !sync_n;

    assign period_line = (period >= 11'(LINE_MIN)) && (period <= 11'(LINE_MAX));
    assign period_half = (period >= 11'(HALF_MIN)) && (period <= 11'(HALF_MAX));
    assign pcnt_over   = !fall && (pcnt >= 11'(LINE_MAX));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 8'hFF;
            run_cnt  <= '0;
            sync_n   <= 1'b1;
            rise_q   <= 1'b0;
            wcnt     <= '0;
            pcnt     <= '0;
            period   <= '0;
        end else begin
            sample_q <= sample_in;
            rise_q   <= rise;
            if (below == sync_n) begin
                if (toggle) begin
                    sync_n  <= ~sync_n;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 3'd1;
                end
            end else begin
                run_cnt <= '0;
            end

            if (fall)
                wcnt <= '0;
            else if (!sync_n && wcnt != 10'h3FF)
                wcnt <= wcnt + 10'd1;

            if (fall) begin
                period <= pcnt;
                pcnt   <= '0;
            end else if (pcnt != 11'h7FF) begin
                pcnt <= pcnt + 11'd1;
            end
        end
    end

    always_comb begin
        if (wcnt >= 10'(HS_MIN) && wcnt <= 10'(HS_MAX))
            cls = P_NORMAL;
        else if (wcnt >= 10'(EQ_MIN) && wcnt <= 10'(EQ_MAX))
            cls = P_EQ;
        else if (wcnt >= 10'(BROAD_MIN))
            cls = P_BROAD;
        else
            cls = P_ERR;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_SEARCH;
        else
            state_q <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state_q;
        hsync_next  = 1'b0;
        vsync_next  = 1'b0;
        perr_next   = 1'b0;
        parity_next = parity_q;
        if (rise_q) begin
            hsync_next = (cls == P_NORMAL);
            perr_next  = (cls == P_ERR);
            // Anything a state does not expect lands in LINES or SEARCH.
            state_next = (cls == P_NORMAL) ? S_LINES : S_SEARCH;
            unique case (state_q)
                S_SEARCH: ;
                S_LINES: begin
                    if (cls == P_EQ) begin
                        if (period_line) begin
                            parity_next = 1'b0;
                            state_next  = S_PRE_EQ;
                        end else if (period_half) begin
                            parity_next = 1'b1;
                            state_next  = S_PRE_EQ;
                        end
                    end else if (cls == P_BROAD) begin
                        state_next = S_BROAD;
                    end
                end
                S_PRE_EQ: begin
                    if (cls == P_EQ) begin
                        state_next = S_PRE_EQ;
                    end else if (cls == P_BROAD) begin
                        state_next = S_BROAD;
                        vsync_next = 1'b1;
                    end
                end
                S_BROAD: begin
                    if (cls == P_BROAD)
                        state_next = S_BROAD;
                    else if (cls == P_EQ)
                        state_next = S_POST_EQ;
                end
                S_POST_EQ: begin
                    if (cls == P_EQ)
                        state_next = S_POST_EQ;
                end
                default: state_next = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            pulse_err <= 1'b0;
            parity_q  <= 1'b0;
            field     <= 1'b0;
            line      <= '0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            pulse_err <= perr_next;
            parity_q  <= parity_next;

            if (vsync_next) begin
                field <= parity_q;
                line  <= '0;
            end else if (hsync_next && line != 10'h3FF) begin
                line <= line + 10'd1;
            end

            // Lock tracks consecutive full-line NORMAL syncs; EQ/BROAD are neutral.
            if (perr_next || pcnt_over) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (hsync_next) begin
                if (!period_line)
                    lock_cnt <= '0;
                else if (lock_cnt == 3'd7)
                    locked <= 1'b1;
                else
                    lock_cnt <= lock_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pal_sync_sep.sv
// Directed bench for pal_sync_sep: clean lines, glitch rejection, both field
// intervals, error/loss handling and asynchronous reset.
`timescale 1ns/1ps
module tb_pal_sync_sep;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sync_n;
    logic       hsync;
    logic       vsync;
    logic       field;
    logic [9:0] line;
    logic       locked;
    logic       pulse_err;

    pal_sync_sep dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .sample_in (sample_in),
        .sync_n    (sync_n),
        .hsync     (hsync),
        .vsync     (vsync),
        .field     (field),
        .line      (line),
        .locked    (locked),
        .pulse_err (pulse_err)
    );

    always #35 pclk = ~pclk;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;

    int hs_cnt = 0, vs_cnt = 0, perr_cnt = 0, fall_cnt = 0, rise_cnt = 0;
    int hs_long = 0, excl_bad = 0, gap_bad = 0;
    int lock_at_hs = -1, vs_rise_idx = -1, vs_line = -1, vs_gap = -1;
    int last_hs = 0, last_fall = 0, last_rise = 0, unlock_cyc = 0;
    logic gap_chk = 1'b0;
    logic sync_p = 1'b1, hs_p = 1'b0, locked_p = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Event monitor, sampling 10 ns after each rising edge.
    always @(posedge pclk) begin
        #10;
        if (rst_n) begin
            if (sync_p && !sync_n) begin fall_cnt++; last_fall = cyc; end
            if (!sync_p && sync_n) begin rise_cnt++; last_rise = cyc; end
            if (hsync) begin
                hs_cnt++;
                if (gap_chk && hs_cnt > 1 && (cyc - last_hs) != 914) gap_bad++;
                last_hs = cyc;
            end
            if (hsync && hs_p) hs_long++;
            if ((hsync && pulse_err) || (hsync && vsync)) excl_bad++;
            if (vsync) begin
                vs_cnt++;
                vs_rise_idx = rise_cnt;
                vs_line = int'(line);
                vs_gap = cyc - last_rise;
            end
            if (pulse_err) perr_cnt++;
            if (locked && !locked_p) lock_at_hs = hs_cnt;
            if (!locked && locked_p) unlock_cyc = cyc;
        end
        sync_p = sync_n;
        hs_p = hsync;
        locked_p = locked;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [7:0] v, input int n);
        repeat (n) begin
            sample_in = v;
            @(negedge pclk);
        end
    endtask

    task automatic pulse(input int low, input int total);
        drive(8'd0, low);
        drive(8'd100, total - low);
    endtask

    initial begin
        // Reset with random samples
        rst_n = 1'b0;
        repeat (10) begin
            sample_in = 8'($urandom);
            @(negedge pclk);
        end
        check("rst_sync_n", 32'(sync_n), 32'd1);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_field", 32'(field), 32'd0);
        check("rst_line", 32'(line), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse_err", 32'(pulse_err), 32'd0);

        // Release mid-pulse: 30-sample remnant is an EQ in SEARCH, no strobe
        sample_in = 8'd0;
        rst_n = 1'b1;
        drive(8'd0, 30);
        drive(8'd100, 884);
        check("partial_fall_seen", 32'(fall_cnt), 32'd1);
        check("partial_no_hsync", 32'(hs_cnt), 32'd0);
        check("partial_no_perr", 32'(perr_cnt), 32'd0);
        check("partial_no_vsync", 32'(vs_cnt), 32'd0);

        // Clean lines
        gap_chk = 1'b1;
        repeat (20) pulse(67, 914);
        check("clean_hs_count", 32'(hs_cnt), 32'd20);
        check("clean_line", 32'(line), 32'd20);
        check("clean_lock_at", 32'(lock_at_hs), 32'd8);
        check("clean_locked", 32'(locked), 32'd1);
        check("clean_gap_bad", 32'(gap_bad), 32'd0);
        check("clean_perr", 32'(perr_cnt), 32'd0);
        check("clean_hs_long", 32'(hs_long), 32'd0);

        // Glitch rejection: 2-sample dip mid-line
        drive(8'd0, 67);
        drive(8'd100, 400);
        drive(8'd0, 2);
        drive(8'd100, 445);
        check("glitch_fall_count", 32'(fall_cnt), 32'd22);
        check("glitch_hs_count", 32'(hs_cnt), 32'd21);
        check("glitch_locked", 32'(locked), 32'd1);
        check("glitch_gap_bad", 32'(gap_bad), 32'd0);
        gap_chk = 1'b0;

        // Field 0 interval: first EQ a full line after the last sync
        repeat (5) pulse(33, 457);
        repeat (5) pulse(390, 457);
        repeat (5) pulse(33, 457);
        check("f0_vs_count", 32'(vs_cnt), 32'd1);
        check("f0_vs_rise_idx", 32'(vs_rise_idx), 32'd28);
        check("f0_vs_after_rise", 32'(vs_gap), 32'd1);
        check("f0_vs_line", 32'(vs_line), 32'd0);
        check("f0_field", 32'(field), 32'd0);
        check("f0_line_zero", 32'(line), 32'd0);
        repeat (3) pulse(67, 914);
        check("f0_line_after", 32'(line), 32'd3);
        check("f0_hs_count", 32'(hs_cnt), 32'd24);
        check("f0_locked", 32'(locked), 32'd1);

        // Field 1 interval: first EQ half a line after the last sync
        pulse(67, 914);
        pulse(67, 457);
        repeat (5) pulse(33, 457);
        check("f1_field_pending", 32'(field), 32'd0);
        check("f1_no_early_vs", 32'(vs_cnt), 32'd1);
        repeat (5) pulse(390, 457);
        repeat (5) pulse(33, 457);
        check("f1_vs_count", 32'(vs_cnt), 32'd2);
        check("f1_vs_rise_idx", 32'(vs_rise_idx), 32'd48);
        check("f1_field", 32'(field), 32'd1);
        check("f1_line_zero", 32'(line), 32'd0);
        repeat (3) pulse(67, 914);
        check("f1_line_after", 32'(line), 32'd3);
        check("f1_hs_count", 32'(hs_cnt), 32'd29);
        check("f1_locked", 32'(locked), 32'd1);
        check("excl_bad", 32'(excl_bad), 32'd0);

        // Error pulse drops lock and returns to SEARCH
        pulse(150, 914);
        check("err_perr_count", 32'(perr_cnt), 32'd1);
        check("err_locked", 32'(locked), 32'd0);
        check("err_hs_count", 32'(hs_cnt), 32'd29);
        pulse(33, 457);
        pulse(390, 457);
        check("search_no_vsync", 32'(vs_cnt), 32'd2);
        drive(8'd100, 3000);
        check("flat_locked", 32'(locked), 32'd0);

        // Relock after saturated period, then loss of sync
        repeat (10) pulse(67, 914);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_lock_at", 32'(lock_at_hs), 32'd38);
        check("relock_line", 32'(line), 32'd13);
        drive(8'd100, 1200);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_delay", 32'(unlock_cyc - last_fall), 32'd951);
        check("final_perr", 32'(perr_cnt), 32'd1);
        check("final_hs_long", 32'(hs_long), 32'd0);

        // Asynchronous reset in the middle of a pulse
        drive(8'd0, 20);
        check("midpulse_sync_low", 32'(sync_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_sync_n", 32'(sync_n), 32'd1);
        check("async_rst_line", 32'(line), 32'd0);
        @(negedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
